rw_bram_arbiter: RTL

- Shares the single-port random-walk BRAM (13-bit address, 32-bit data) between several requesters: the walk engine, the score engine, and host load/readback.
- Arbitration is round-robin with a per-requester lock, so read-modify-write sequences are atomic (for example, counter read then counter+1 write).
- Sits between requester engines and the bram instance, and owns its i_addr/i_write/i_data ports.

---
 rtl/rw_bram_pkg.sv | 26 ++
 rtl/rw_bram_arbiter_rr.sv | 34 +++
 rtl/rw_bram_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rw_bram_pkg.sv
// Shared widths, table bases and requester ids
// for the random-walk BRAM arbiter slice.
package rw_bram_pkg;

  localparam int ADDR_WIDTH = 13;
  localparam int DATA_WIDTH = 32;

  localparam int SEED_OFFSET        = 10;
  localparam int NEI_TABLE_OFFSET   = 30;
  localparam int SCORE_TABLE_OFFSET = 100;

  typedef enum logic [1:0] {
    REQ_WALK  = 2'd0,
    REQ_SCORE = 2'd1,
    REQ_HOST  = 2'd2
  } req_id_e;

  // Id field sized for the largest supported requester count.
  localparam int ID_W = 2;

  typedef struct packed {
    logic            rd;
    logic [ID_W-1:0] id;
  } rsp_tag_t;

endpackage

// File: rtl/rw_bram_arbiter_rr.sv
// Combinational round-robin one-hot grant.
// Search starts at ptr and wraps modulo N.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  grant
);

  logic [N-1:0] elig;
  logic [PW:0]  sum;
  logic         found;

  assign elig = req & mask;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N))
        sum = sum - (PW+1)'(N);
      if (!found && elig[sum[PW-1:0]]) begin
        grant[sum[PW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rw_bram_arbiter.sv
// Round-robin arbiter with per-requester lock
// in front of the single-port random-walk BRAM.
module rw_bram_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = rw_bram_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = rw_bram_pkg::DATA_WIDTH,
  parameter int RD_LAT     = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_write,
  input  logic [NUM_REQ-1:0]            i_req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic [ADDR_WIDTH-1:0]         o_bram_addr,
  output logic                          o_bram_write,
  output logic [DATA_WIDTH-1:0]         o_bram_wdata,
  input  logic [DATA_WIDTH-1:0]         i_bram_rdata,
  output logic                          o_busy
);

  import rw_bram_pkg::*;

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      owner_q;
  logic               lock_q;
  logic [NUM_REQ-1:0] lock_mask;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      gid;
  logic [PW-1:0]      ptr_nxt;
  logic               xfer;
  rsp_tag_t           tag_new;
  rsp_tag_t           tag_out;
  rsp_tag_t [RD_LAT:0] pipe_q;
  logic               pipe_busy;

  always_comb begin
    lock_mask = '1;
    if (lock_q)
      lock_mask = NUM_REQ'(1) << owner_q;
  end

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .req   (i_req_valid),
    .ptr   (ptr_q),
    .mask  (lock_mask),
    .grant (grant)
  );

  assign o_req_ready = i_rst_n ? grant : '0;
  assign xfer        = |o_req_ready;

  always_comb begin
    gid = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (o_req_ready[k])
        gid = PW'(k);
  end

  assign ptr_nxt = (gid == PW'(NUM_REQ - 1)) ?
                   '0 : gid + 1'b1;

  // While locked only the owner can transfer,
  // so gid doubles as the next owner.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q   <= '0;
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else if (xfer) begin
      ptr_q   <= ptr_nxt;
      lock_q  <= i_req_lock[gid];
      owner_q <= gid;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bram_addr  <= '0;
      o_bram_write <= 1'b0;
      o_bram_wdata <= '0;
    end else begin
      o_bram_write <= xfer & i_req_write[gid];
      if (xfer) begin
        o_bram_addr  <=
          i_req_addr[gid*ADDR_WIDTH +: ADDR_WIDTH];
        o_bram_wdata <=
          i_req_wdata[gid*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    tag_new.rd = xfer & ~i_req_write[gid];
    tag_new.id = ID_W'(gid);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      pipe_q <= '0;
    else
      pipe_q <= {pipe_q[RD_LAT-1:0], tag_new};
  end

  assign tag_out = pipe_q[RD_LAT];

  assign o_rsp_valid = tag_out.rd ?
                       (NUM_REQ'(1) << tag_out.id) : '0;
  assign o_rsp_data  = tag_out.rd ? i_bram_rdata : '0;

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i <= RD_LAT; i++)
      pipe_busy = pipe_busy | pipe_q[i].rd;
  end

  assign o_busy = pipe_busy | o_bram_write | lock_q;

endmodule
